tb_irq_injector: RTL
====================

TB_IRQ_INJECTOR -- requirements
Module: tb_irq_injector

Interface
REQ-001 Parameter NUM_CH, default 3: number of interrupt channels (1..8).
REQ-002 Parameter PC_W, default 32: commit PC width.
REQ-003 Parameter CNT_W, default 32: width of all statistics counters.
REQ-004 Parameter DLY_W, default 10: delay-mask width.
REQ-005 Parameter STOP_HITS, default 32: tohost hit count beyond which injection stops.
REQ-006 Parameter DONE_HITS, default 8: tohost hit count that ends the test.
REQ-007 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-008 Ports: rst  in  1  asynchronous, active-high reset.
REQ-009 Ports: cmt_valid  in  1  commit valid; cmt_pc  in  PC_W  committed PC.
REQ-010 Ports: ir_valid, ir_ready  in  1 each  EXU instruction handshake.
REQ-011 Ports: arm_pc, tohost_pc  in  PC_W each  arming PC, test-end PC.
REQ-012 Ports: ack_pc  in  NUM_CH*PC_W  per-channel handler-exit PC; ch k at bits [k*PC_W +: PC_W].
REQ-013 Ports: dly_mask  in  NUM_CH*DLY_W  per-channel delay mask; ch_en  in  NUM_CH  channel enable; seed  in  16  LFSR seed.
REQ-014 Ports: irq  out  NUM_CH  interrupt requests; armed, done  out  1 each.
REQ-015 Ports: cycle_cnt, instr_cnt, tohost_cnt, tohost_cycle  out  CNT_W each.

Function
REQ-016 All outputs SHALL be registered; all SHALL be 0 during and after reset.
REQ-017 cycle_cnt SHALL increment by 1 every cycle after reset, wrapping at 2^CNT_W.
REQ-018 hit = cmt_valid & (cmt_pc == tohost_pc); each hit SHALL increment tohost_cnt, saturating at all-ones.
REQ-019 On the first hit, tohost_cycle SHALL capture the cycle_cnt value of that cycle; later hits SHALL not change it.
REQ-020 instr_cnt SHALL increment on ir_valid & ir_ready only while no hit has yet been seen; the hit cycle itself still counts.
REQ-021 armed SHALL set on the cycle after cmt_valid & (cmt_pc == arm_pc) and stay set until reset.
REQ-022 stop = (tohost_cnt > STOP_HITS), using the registered count.
REQ-023 LFSR: 16-bit Galois, polynomial mask 16'hB400, shifts right every cycle; loaded from seed at reset, 16'h0001 if seed is 0.
REQ-024 Channel k random value r_k = LFSR rotated left by 4*k, low DLY_W bits; delay_k = 1 + (r_k & dly_mask[k]), range 1..2^DLY_W.
REQ-025 Per-channel FSM states: IDLE, DELAY, ASSERT, DONE; reset state IDLE.
REQ-026 IDLE -> DELAY when armed & ch_en[k]; load delay_k into down-counter.
REQ-027 DELAY: counter decrements each cycle; at counter==1 go to ASSERT; irq[k] rises the same edge, so assertion lands delay_k cycles after entry.
REQ-028 ASSERT: irq[k]=1 until cmt_valid & (cmt_pc == ack_pc[k]); irq[k]=0 on the next edge.
REQ-029 On ack: go to DONE if stop, else to DELAY with a fresh delay_k.
REQ-030 DONE: irq[k]=0 permanently until reset.
REQ-031 ch_en[k] low in IDLE or DELAY SHALL hold or return the channel to IDLE.
REQ-032 ch_en[k] low in ASSERT SHALL not drop irq[k]; the channel waits for ack, then goes to IDLE.
REQ-033 Ack PC seen outside ASSERT SHALL be ignored.
REQ-034 Channels SHALL be independent; one commit may ack several channels in the same cycle.
REQ-035 done SHALL set when tohost_cnt >= DONE_HITS and irq == 0, and stay set until reset.
REQ-036 If arm_pc and tohost_pc hit in the same cycle, both effects SHALL apply.

Reset
REQ-037 Asserting rst at any time, including mid-ASSERT, SHALL immediately clear irq, all counters, armed and done, and force all FSMs to IDLE.
REQ-038 After rst is released, the LFSR SHALL restart from seed, so a fixed seed gives a reproducible delay sequence.

Verification
REQ-039 Reset then 100 idle cycles -> cycle_cnt=100; irq=0, armed=0, instr_cnt=0.
REQ-040 seed=0, dly_mask=0 on all channels, arm at cycle 10 -> every enabled irq rises 2 cycles after armed rises; ack on ch1 PC -> only irq[1] falls next cycle and re-asserts 1 cycle later.
REQ-041 STOP_HITS=2: 3 tohost hits, then ack on all channels -> all FSMs reach DONE and irq stays 0 for 1000 cycles.
REQ-042 Hits at cycles 50 and 80; handshakes every cycle -> tohost_cycle=50, tohost_cnt=2, instr_cnt frozen from cycle 51.
REQ-043 rst pulsed while irq[0]=1 -> irq[0] falls asynchronously; after re-arm with the same seed, assertion times repeat exactly.
REQ-044 DONE_HITS=8: 8th hit while irq[2]=1 -> done stays 0 until ch2 is acked, then rises the next cycle.

Source files
------------

// File: rtl/tb_irq_injector.sv
// rtl/tb_irq_injector.sv - Testbench-side interrupt injector: randomized per-channel IRQ timing plus run statistics.
module tb_irq_injector #(
    parameter int NUM_CH    = 3,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 32,
    parameter int DLY_W     = 10,
    parameter int STOP_HITS = 32,
    parameter int DONE_HITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmt_valid,
    input  logic [PC_W-1:0]         cmt_pc,
    input  logic                    ir_valid,
    input  logic                    ir_ready,
    input  logic [PC_W-1:0]         arm_pc,
    input  logic [PC_W-1:0]         tohost_pc,
    input  logic [NUM_CH*PC_W-1:0]  ack_pc,
    input  logic [NUM_CH*DLY_W-1:0] dly_mask,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [15:0]             seed,
    output logic [NUM_CH-1:0]       irq,
    output logic                    armed,
    output logic                    done,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        instr_cnt,
    output logic [CNT_W-1:0]        tohost_cnt,
    output logic [CNT_W-1:0]        tohost_cycle
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ASSERT, S_DONE} ch_state_t;

    localparam logic [15:0]      LFSR_POLY = 16'hB400;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STOP_LIM  = CNT_W'(STOP_HITS);
    localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_HITS);
    localparam logic [DLY_W:0]   DLY_ONE   = (DLY_W+1)'(1);

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  tohost_cnt_q, tohost_cnt_d;
    logic [CNT_W-1:0]  tohost_cycle_q, tohost_cycle_d;
    logic              armed_q, armed_d;
    logic              done_q, done_d;
    logic [15:0]       lfsr_q, lfsr_d, lfsr_cur;
    logic              lfsr_run_q;
    logic [NUM_CH-1:0] irq_w;

    logic hit, arm_hit, stop, hit_seen;

    assign hit      = cmt_valid && (cmt_pc == tohost_pc);
    assign arm_hit  = cmt_valid && (cmt_pc == arm_pc);
    assign stop     = tohost_cnt_q > STOP_LIM;
    assign hit_seen = tohost_cnt_q != '0;

    // Until the first post-reset edge the generator reads straight from the seed,
    // so a given seed always yields the same delay sequence after any reset.
    assign lfsr_cur = lfsr_run_q ? lfsr_q : ((seed == 16'h0000) ? 16'h0001 : seed);
    assign lfsr_d   = lfsr_cur[0] ? ((lfsr_cur >> 1) ^ LFSR_POLY) : (lfsr_cur >> 1);

    always_comb begin
        cycle_cnt_d    = cycle_cnt_q + CNT_ONE;
        instr_cnt_d    = instr_cnt_q;
        tohost_cnt_d   = tohost_cnt_q;
        tohost_cycle_d = tohost_cycle_q;
        armed_d        = armed_q | arm_hit;
        done_d         = done_q | ((tohost_cnt_q >= DONE_LIM) && (irq_w == '0));
        if (ir_valid && ir_ready && !hit_seen)
            instr_cnt_d = instr_cnt_q + CNT_ONE;
        if (hit) begin
            if (tohost_cnt_q != '1)
                tohost_cnt_d = tohost_cnt_q + CNT_ONE;
            if (!hit_seen)
                tohost_cycle_d = cycle_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
            tohost_cnt_q   <= '0;
            tohost_cycle_q <= '0;
            armed_q        <= 1'b0;
            done_q         <= 1'b0;
            lfsr_q         <= 16'h0001;
            lfsr_run_q     <= 1'b0;
        end else begin
            cycle_cnt_q    <= cycle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
            tohost_cnt_q   <= tohost_cnt_d;
            tohost_cycle_q <= tohost_cycle_d;
            armed_q        <= armed_d;
            done_q         <= done_d;
            lfsr_q         <= lfsr_d;
            lfsr_run_q     <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam int ROT = (4 * k) % 16;

        logic [DLY_W-1:0] mask_k;
        logic [DLY_W:0]   delay_k;
        logic             ack_k;
        ch_state_t        state_q;
        logic [DLY_W:0]   cnt_q;
        logic             irq_bit_q;

        assign mask_k  = dly_mask[k*DLY_W +: DLY_W];
        assign delay_k = (DLY_W+1)'(rotl16(lfsr_cur, ROT) & 16'(mask_k)) + DLY_ONE;
        assign ack_k   = cmt_valid && (cmt_pc == ack_pc[k*PC_W +: PC_W]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                irq_bit_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (armed_q && ch_en[k]) begin
                            state_q <= S_DELAY;
                            cnt_q   <= delay_k;
                        end
                    end
                    S_DELAY: begin
                        if (!ch_en[k]) begin
                            state_q <= S_IDLE;
                        end else if (cnt_q == DLY_ONE) begin
                            state_q   <= S_ASSERT;
                            irq_bit_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - DLY_ONE;
                        end
                    end
                    S_ASSERT: begin
                        // A disabled channel keeps its request up until the handler exits.
                        if (ack_k) begin
                            irq_bit_q <= 1'b0;
                            if (stop) begin
                                state_q <= S_DONE;
                            end else if (!ch_en[k]) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_DELAY;
                                cnt_q   <= delay_k;
                            end
                        end
                    end
                    S_DONE: begin
                        irq_bit_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        irq_bit_q <= 1'b0;
                    end
                endcase
            end
        end

        assign irq_w[k] = irq_bit_q;
    end

    assign irq          = irq_w;
    assign armed        = armed_q;
    assign done         = done_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign instr_cnt    = instr_cnt_q;
    assign tohost_cnt   = tohost_cnt_q;
    assign tohost_cycle = tohost_cycle_q;

endmodule
